// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_ADR,
        S_JALR
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b101
    } imm_t;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        alu_op_t    alu_ctrl;
        imm_t       imm_src;
        logic       illegal;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_IDLE = '0;

    function automatic imm_t imm_for_opcode(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_ctrl_if #(
    parameter int Width = 32
);
    logic [Width-1:0] instr;
    logic             EQ;
    logic             mem_ready;
    logic             mem_req;
    logic             AdrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic [3:0]       ALUctrl;
    logic [2:0]       ImmSrc;
    logic             illegal_instr;

    modport master (
        input  instr, EQ, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, ImmSrc, illegal_instr
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, ImmSrc, illegal_instr
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode for register-register and register-immediate ops.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_b5_i,
    output alu_op_t    alu_ctrl_o
);

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        alu_ctrl_o = ALU_ADD;
        if (opcode_i == OP_R || opcode_i == OP_IMM) begin
            case (funct3_i)
                3'b000: alu_ctrl_o = (opcode_i == OP_R && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                3'b001: alu_ctrl_o = ALU_SLL;
                3'b010: alu_ctrl_o = ALU_SLT;
                3'b011: alu_ctrl_o = ALU_SLTU;
                3'b100: alu_ctrl_o = ALU_XOR;
                3'b101: alu_ctrl_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
                3'b110: alu_ctrl_o = ALU_OR;
                default: alu_ctrl_o = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. Define MULTICYCLE_CTRL_PERF_EN to add the retired_cnt counter.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]         retired_cnt
`endif
);

    state_t    state_q, state_d;
    ctrl_out_t ctl;
    alu_op_t   dec_alu_op;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign is_load = (opcode == OP_LOAD);

    alu_decoder u_alu_decoder (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_b5_i (bus.instr[30]),
        .alu_ctrl_o  (dec_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all clocked state avoid ordering races between flops.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADR;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_JALR:     state_d = S_ALUWB;
            S_JALR_ADR: state_d = S_JALR;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctl = CTRL_IDLE;
        case (state_q)
            S_FETCH: begin
                ctl.mem_req    = 1'b1;
                ctl.adr_src    = ADR_PC;
                ctl.ir_write   = bus.mem_ready;
                ctl.pc_write   = bus.mem_ready;
                ctl.alu_src_a  = SRCA_PC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALU;
            end
            S_DECODE: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
                ctl.imm_src   = imm_for_opcode(opcode);
                ctl.illegal   = !(opcode inside {OP_LOAD, OP_STORE, OP_R, OP_IMM,
                                                 OP_BRANCH, OP_JAL, OP_JALR});
            end
            S_MEMADR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.imm_src   = is_load ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                ctl.mem_req = 1'b1;
                ctl.adr_src = ADR_ALUOUT;
            end
            S_MEMWB: begin
                ctl.result_src = RES_RDATA;
                ctl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctl.mem_req   = 1'b1;
                ctl.adr_src   = ADR_ALUOUT;
                ctl.mem_write = bus.mem_ready;
            end
            S_EXECR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_RS2;
                ctl.alu_ctrl  = dec_alu_op;
            end
            S_EXECI: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.imm_src   = IMM_I;
                ctl.alu_ctrl  = dec_alu_op;
            end
            S_ALUWB: begin
                ctl.result_src = RES_ALUOUT;
                ctl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a  = SRCA_RS1;
                ctl.alu_src_b  = SRCB_RS2;
                ctl.alu_ctrl   = ALU_SUB;
                ctl.result_src = RES_ALUOUT;
                ctl.pc_write   = (funct3 == 3'b000) ?  bus.EQ :
                                 (funct3 == 3'b001) ? !bus.EQ : 1'b0;
            end
            S_JAL, S_JALR: begin
                // Both states reload PC from ALUOut while the ALU forms OldPC+4 for the link.
                ctl.alu_src_a  = SRCA_OLDPC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALUOUT;
                ctl.pc_write   = 1'b1;
            end
            S_JALR_ADR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.imm_src   = IMM_I;
            end
            default: ctl = CTRL_IDLE;
        endcase
        // Reset silences every control line at once, abandoning any access in flight.
        if (rst) ctl = CTRL_IDLE;
    end

    assign bus.mem_req       = ctl.mem_req;
    assign bus.AdrSrc        = ctl.adr_src;
    assign bus.IRWrite       = ctl.ir_write;
    assign bus.PCWrite       = ctl.pc_write;
    assign bus.RegWrite      = ctl.reg_write;
    assign bus.MemWrite      = ctl.mem_write;
    assign bus.ALUSrcA       = ctl.alu_src_a;
    assign bus.ALUSrcB       = ctl.alu_src_b;
    assign bus.ResultSrc     = ctl.result_src;
    assign bus.ALUctrl       = ctl.alu_ctrl;
    assign bus.ImmSrc        = ctl.imm_src;
    assign bus.illegal_instr = ctl.illegal;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    assign retire = (state_q inside {S_ALUWB, S_MEMWB, S_BRANCH}) ||
                    (state_q == S_MEMWRITE && bus.mem_ready);

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours MULTICYCLE_CTRL_PERF_EN.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   tests    = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.Width(32)) bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_cnt;
`endif

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    // {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, ImmSrc, illegal}
    logic [19:0] obs;
    assign obs = {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUctrl, bus.ImmSrc, bus.illegal_instr};

    function automatic logic [19:0] ov(
        input logic req, input logic adr, input logic irw, input logic pcw,
        input logic rw, input logic mw, input logic [1:0] asa, input logic [1:0] asb,
        input logic [1:0] rs, input logic [3:0] alu, input logic [2:0] imm, input logic ill);
        return {req, adr, irw, pcw, rw, mw, asa, asb, rs, alu, imm, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive this cycle's inputs, sample after settling, then move to the next negedge.
    task automatic cyc(input string tag, input logic mr, input logic eq, input logic [19:0] exp_v);
        bus.mem_ready = mr;
        bus.EQ        = eq;
        #1;
        check(tag, 32'(obs), 32'(exp_v));
        @(negedge clk);
    endtask

    logic [19:0] v_fetch, v_fetch_wait, v_aluwb, v_dec_i, v_dec_s, v_dec_b, v_dec_j;

    initial begin
        v_fetch      = ov(1, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 4'b0000, 3'b000, 0);
        v_fetch_wait = ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 4'b0000, 3'b000, 0);
        v_aluwb      = ov(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
        v_dec_i      = ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b000, 0);
        v_dec_s      = ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b001, 0);
        v_dec_b      = ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b010, 0);
        v_dec_j      = ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b101, 0);

        rst           = 1'b1;
        bus.instr     = 32'h0;
        bus.mem_ready = 1'b0;
        bus.EQ        = 1'b0;
        @(negedge clk);
        cyc("reset.idle", 1, 1, 20'h0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("reset.cnt", retired_cnt, 32'd0);
`endif
        rst = 1'b0;

        // add x3,x1,x2
        bus.instr = 32'h002081B3;
        cyc("add.fetch",  1, 0, v_fetch);
        cyc("add.decode", 1, 0, v_dec_i);
        cyc("add.execr",  1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0000, 3'b000, 0));
        cyc("add.aluwb",  1, 0, v_aluwb);

        // sra x3,x1,x2
        bus.instr = 32'h4020D1B3;
        cyc("sra.fetch",  1, 0, v_fetch);
        cyc("sra.decode", 1, 0, v_dec_i);
        cyc("sra.execr",  1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0111, 3'b000, 0));
        cyc("sra.aluwb",  1, 0, v_aluwb);

        // srai x3,x1,2
        bus.instr = 32'h4020D193;
        cyc("srai.fetch",  1, 0, v_fetch);
        cyc("srai.decode", 1, 0, v_dec_i);
        cyc("srai.execi",  1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0111, 3'b000, 0));
        cyc("srai.aluwb",  1, 0, v_aluwb);

        // addi x3,x1,-1024: bit 30 set in the immediate must still be ADD
        bus.instr = 32'hC0008193;
        cyc("addi.fetch",  1, 0, v_fetch);
        cyc("addi.decode", 1, 0, v_dec_i);
        cyc("addi.execi",  1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 0));
        cyc("addi.aluwb",  1, 0, v_aluwb);

        // lw x4,4(x0) with three wait cycles
        bus.instr = 32'h00402203;
        cyc("lw.fetch",   1, 0, v_fetch);
        cyc("lw.decode",  1, 0, v_dec_i);
        cyc("lw.memadr",  1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 0));
        for (int i = 0; i < 3; i++)
            cyc("lw.memread.wait", 0, 0, ov(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0));
        cyc("lw.memread", 1, 0, ov(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0));
        cyc("lw.memwb",   1, 0, ov(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 4'b0000, 3'b000, 0));

        // sw x4,4(x0) with one wait cycle
        bus.instr = 32'h00402223;
        cyc("sw.fetch",       1, 0, v_fetch);
        cyc("sw.decode",      1, 0, v_dec_s);
        cyc("sw.memadr",      1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b001, 0));
        cyc("sw.memwr.wait",  0, 0, ov(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0));
        cyc("sw.memwr",       1, 0, ov(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0));

        // beq EQ=1 taken
        bus.instr = 32'h00208463;
        cyc("beq.fetch",  1, 1, v_fetch);
        cyc("beq.decode", 1, 1, v_dec_b);
        cyc("beq.branch", 1, 1, ov(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 0));

        // bne EQ=1 not taken, then EQ=0 taken
        bus.instr = 32'h00209463;
        cyc("bne1.fetch",  1, 1, v_fetch);
        cyc("bne1.decode", 1, 1, v_dec_b);
        cyc("bne1.branch", 1, 1, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 0));
        cyc("bne0.fetch",  1, 0, v_fetch);
        cyc("bne0.decode", 1, 0, v_dec_b);
        cyc("bne0.branch", 1, 0, ov(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 0));

        // blt: unsupported funct3 never writes PC
        bus.instr = 32'h0020C463;
        cyc("blt.fetch",  1, 0, v_fetch);
        cyc("blt.decode", 1, 0, v_dec_b);
        cyc("blt.branch", 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 0));

        // jal x1,8
        bus.instr = 32'h008000EF;
        cyc("jal.fetch",  1, 0, v_fetch);
        cyc("jal.decode", 1, 0, v_dec_j);
        cyc("jal.jal",    1, 0, ov(0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 4'b0000, 3'b000, 0));
        cyc("jal.aluwb",  1, 0, v_aluwb);

        // jalr x1,0(x5)
        bus.instr = 32'h000280E7;
        cyc("jalr.fetch",  1, 0, v_fetch);
        cyc("jalr.decode", 1, 0, v_dec_i);
        cyc("jalr.adr",    1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 0));
        cyc("jalr.jalr",   1, 0, ov(0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 4'b0000, 3'b000, 0));
        cyc("jalr.aluwb",  1, 0, v_aluwb);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf.after_jalr", retired_cnt, 32'd12);
`endif

        // illegal opcode: one-cycle flag, straight back to FETCH
        bus.instr = 32'h0000007F;
        cyc("ill.fetch",  1, 0, v_fetch);
        cyc("ill.decode", 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b000, 1));
        cyc("ill.refetch", 0, 0, v_fetch_wait);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf.illegal", retired_cnt, 32'd12);
`endif

        // reset during a stalled load read
        bus.instr = 32'h00402203;
        cyc("rstmid.fetch",  1, 0, v_fetch);
        cyc("rstmid.decode", 1, 0, v_dec_i);
        cyc("rstmid.memadr", 1, 0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 0));
        cyc("rstmid.memread", 0, 0, ov(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0));
        rst = 1'b1;
        cyc("rstmid.asserted", 0, 0, 20'h0);
        cyc("rstmid.ready_ignored", 1, 0, 20'h0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf.rstmid", retired_cnt, 32'd0);
`endif
        rst = 1'b0;
        cyc("rstmid.fetch_wait", 0, 0, v_fetch_wait);
        cyc("rstmid.fetch_hold", 0, 0, v_fetch_wait);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core. Replaces single-cycle decode with an FSM that steps a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects, register and memory write enables, and a request/ready handshake to a unified instruction/data memory.
- Sits between the instruction register (IR) output and the datapath control inputs.

Parameters:
- Width, 32, instruction and datapath word width.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr  in  Width  IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- EQ  in  1  ALU zero flag, valid during the BRANCH state.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from the result bus.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data store enable.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- ResultSrc  out  2  result bus select: 00 = ALUOut, 01 = read data, 10 = ALU result (direct).
- ALUctrl  out  4  ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- ImmSrc  out  3  I 000, S 001, B 010, J 101.
- illegal_instr  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

Behaviour:
- Reset: state goes to FETCH asynchronously. While rst is high, every output is 0, including mem_req. The first FETCH request is issued the cycle after rst deasserts.
- Reset mid-operation: any pending mem_req is abandoned, with no PCWrite, RegWrite or MemWrite. rst has priority over mem_ready in the same cycle.
- FETCH:
  - AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, ALUctrl=ADD, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUctrl=ADD, so ALUOut becomes the branch or JAL target.
  - ImmSrc is selected from the opcode.
  - Next state by opcode:
    - 0000011 (load) or 0100011 (store) -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - 1100111 -> JALR_ADR.
    - Any other opcode -> FETCH with illegal_instr=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD; ImmSrc is I for loads, S for stores. Next state MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AdrSrc=1, mem_req=1. On mem_ready go to MEMWB; otherwise hold.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, mem_req=1, MemWrite=mem_ready. On mem_ready go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00; ALUctrl from funct3/funct7 (bit 30 selects SUB/SRA). Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I; ALUctrl from funct3 (SRAI uses funct7). Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. PCWrite=EQ for funct3=000 and ~EQ for funct3=001; other funct3 values give PCWrite=0. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1 (PC <= target). Next ALUWB, which writes OldPC+4 to rd.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, ADD. Next JALR.
- JALR: ResultSrc=00, PCWrite=1; ALU computes OldPC+4. Next ALUWB. rs1==rd is safe because rs1 is consumed before writeback.
- Latency with zero-wait memory:
  - R/I-type and store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
  - Each cycle mem_ready is low adds one cycle.
- Outputs not listed for a state are 0.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_EN.
- When defined, adds output retired_cnt [31:0]. It resets to 0 and increments on the final cycle of each instruction: ALUWB, MEMWB, BRANCH, and MEMWRITE with mem_ready. It wraps at 2^32.
- Illegal instructions are not counted.
- When undefined, the port and its logic are absent.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum.
  - Opcode constants.
  - ALUctrl codes.
  - ImmSrc codes.
  - AdrSrc, ALUSrcA, ALUSrcB and ResultSrc select codes.
- Sub-module alu_decoder: combinational opcode/funct3/funct7 -> ALUctrl, used by EXECR and EXECI.

Test Plan:
- Reset mid-access: assert rst in MEMREAD with mem_ready=0 -> all outputs 0 immediately; after release, FETCH with mem_req=1; no RegWrite observed.
- add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> PCWrite and IRWrite in cycle 1, ALUctrl=0000 in cycle 3, RegWrite only in cycle 4, back in FETCH in cycle 5.
- lw x4,4(x0) (0x00402203), mem_ready low for 3 cycles in MEMREAD -> mem_req high 4 cycles with AdrSrc=1; RegWrite with ResultSrc=01 once; 8 cycles total.
- beq 0x00208463 with EQ=1 -> PCWrite=1 in BRANCH. bne 0x00209463 with EQ=1 -> PCWrite=0; both return to FETCH after 3 cycles.
- jalr x1,0(x5) (0x000280E7) -> FETCH, DECODE, JALR_ADR, JALR, ALUWB; PCWrite in FETCH and JALR; RegWrite only in ALUWB.
- Illegal 0x0000007F -> illegal_instr high for exactly 1 cycle in DECODE, then FETCH; MemWrite and RegWrite never asserted; with PERF_EN, retired_cnt unchanged.
